team_06_sram_arbiter: RTL and testbench

Shares the single SRAM port between two requesters: master 0, the echo/reverb read-write engine, and master 1, the host/loader path that fills or dumps audio memory. The block arbitrates with round-robin priority and sequences each single-word transaction through the SRAM read/write strobes. It waits on the SRAM busy flag, then returns data and an acknowledge to the winning master. A timeout guards against a hung SRAM.

---
 rtl/team_06_sram_arbiter.sv | 184 ++++++++++++++++++
 tb/tb_team_06_sram_arbiter.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/team_06_sram_arbiter.sv
// Two-master round-robin arbiter for a single SRAM port. Each granted request
// becomes one read or write strobe, a bounded wait on sram_busy, and a
// one-cycle ack (with err on timeout) back to the winning master only.
module team_06_sram_arbiter #(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned SEL_W    = 4,
  parameter int unsigned MAX_WAIT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  input  logic [SEL_W-1:0]  m0_sel,
  output logic              m0_ack,
  output logic              m0_err,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  input  logic [SEL_W-1:0]  m1_sel,
  output logic              m1_ack,
  output logic              m1_err,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              sram_read,
  output logic              sram_write,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_wdata,
  output logic [SEL_W-1:0]  sram_sel,
  input  logic              sram_busy,
  input  logic [DATA_W-1:0] sram_rdata,
  output logic              grant
);

  localparam int unsigned CntW = $clog2(MAX_WAIT + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(MAX_WAIT);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StIssue = 2'd1;
  localparam logic [1:0] StWait  = 2'd2;
  localparam logic [1:0] StDone  = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              we_q, we_d;
  logic              grant_q, grant_d;
  logic              last_grant_q, last_grant_d;
  logic              read_q, read_d;
  logic              write_q, write_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic              m0_ack_q, m0_ack_d, m1_ack_q, m1_ack_d;
  logic              m0_err_q, m0_err_d, m1_err_q, m1_err_d;
  logic [DATA_W-1:0] m0_rdata_q, m0_rdata_d, m1_rdata_q, m1_rdata_d;

  logic              win;
  logic              fin_ok, fin_to;
  logic [DATA_W-1:0] ret_data;

  // Next-state: arbitration in IDLE, strobe in ISSUE, busy/timeout in WAIT.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    we_d         = we_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    sel_d        = sel_q;
    read_d       = 1'b0;
    write_d      = 1'b0;
    m0_ack_d     = 1'b0;
    m1_ack_d     = 1'b0;
    m0_err_d     = 1'b0;
    m1_err_d     = 1'b0;
    m0_rdata_d   = '0;
    m1_rdata_d   = '0;
    // On a tie the master not served last wins; otherwise the sole requester.
    win          = (m0_req && m1_req) ? ~last_grant_q : m1_req;
    // Busy is not yet valid in the first WAIT cycle (cnt_q == 0).
    fin_ok       = (cnt_q != '0) && !sram_busy;
    fin_to       = !fin_ok && (cnt_q == CntMax);
    ret_data     = (fin_ok && !we_q) ? sram_rdata : '0;

    unique case (state_q)
      StIdle: begin
        if (m0_req || m1_req) begin
          grant_d      = win;
          last_grant_d = win;
          we_d         = win ? m1_we    : m0_we;
          addr_d       = win ? m1_addr  : m0_addr;
          wdata_d      = win ? m1_wdata : m0_wdata;
          sel_d        = win ? m1_sel   : m0_sel;
          read_d       = ~we_d;
          write_d      = we_d;
          state_d      = StIssue;
        end
      end
      StIssue: begin
        cnt_d   = '0;
        state_d = StWait;
      end
      StWait: begin
        if (fin_ok || fin_to) begin
          state_d = StDone;
          if (grant_q) begin
            m1_ack_d   = 1'b1;
            m1_err_d   = fin_to;
            m1_rdata_d = ret_data;
          end else begin
            m0_ack_d   = 1'b1;
            m0_err_d   = fin_to;
            m0_rdata_d = ret_data;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and registered outputs; reset aborts any transaction at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      we_q         <= 1'b0;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      read_q       <= 1'b0;
      write_q      <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      sel_q        <= '0;
      m0_ack_q     <= 1'b0;
      m1_ack_q     <= 1'b0;
      m0_err_q     <= 1'b0;
      m1_err_q     <= 1'b0;
      m0_rdata_q   <= '0;
      m1_rdata_q   <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      we_q         <= we_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      read_q       <= read_d;
      write_q      <= write_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      sel_q        <= sel_d;
      m0_ack_q     <= m0_ack_d;
      m1_ack_q     <= m1_ack_d;
      m0_err_q     <= m0_err_d;
      m1_err_q     <= m1_err_d;
      m0_rdata_q   <= m0_rdata_d;
      m1_rdata_q   <= m1_rdata_d;
    end
  end

  assign sram_read  = read_q;
  assign sram_write = write_q;
  assign sram_addr  = addr_q;
  assign sram_wdata = wdata_q;
  assign sram_sel   = sel_q;
  assign grant      = grant_q;
  assign m0_ack     = m0_ack_q;
  assign m1_ack     = m1_ack_q;
  assign m0_err     = m0_err_q;
  assign m1_err     = m1_err_q;
  assign m0_rdata   = m0_rdata_q;
  assign m1_rdata   = m1_rdata_q;

endmodule

// File: tb/tb_team_06_sram_arbiter.sv
// Directed bench for team_06_sram_arbiter with a small busy-pulse SRAM model.
module tb_team_06_sram_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        m0_req = 1'b0, m0_we = 1'b0, m1_req = 1'b0, m1_we = 1'b0;
  logic [31:0] m0_addr = '0, m0_wdata = '0, m1_addr = '0, m1_wdata = '0;
  logic [3:0]  m0_sel = '0, m1_sel = '0;
  logic        m0_ack, m0_err, m1_ack, m1_err;
  logic [31:0] m0_rdata, m1_rdata;
  logic        sram_read, sram_write, sram_busy, grant;
  logic [31:0] sram_addr, sram_wdata;
  logic [3:0]  sram_sel;
  logic [31:0] sram_rdata = '0;

  int busy_len   = 0;
  int busy_cnt   = 0;
  logic busy_stuck = 1'b0;
  int n_checks   = 0;
  int n_fail     = 0;

  team_06_sram_arbiter #(
    .ADDR_W(32), .DATA_W(32), .SEL_W(4), .MAX_WAIT(8)
  ) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_sel(m0_sel), .m0_ack(m0_ack), .m0_err(m0_err), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_sel(m1_sel), .m1_ack(m1_ack), .m1_err(m1_err), .m1_rdata(m1_rdata),
    .sram_read(sram_read), .sram_write(sram_write), .sram_addr(sram_addr),
    .sram_wdata(sram_wdata), .sram_sel(sram_sel), .sram_busy(sram_busy),
    .sram_rdata(sram_rdata), .grant(grant)
  );

  always #5 clk = ~clk;

  // SRAM model: busy for busy_len cycles starting the cycle after a strobe.
  always @(posedge clk) begin
    if (sram_read || sram_write) busy_cnt <= busy_len;
    else if (busy_cnt != 0)      busy_cnt <= busy_cnt - 1;
  end
  assign sram_busy = busy_stuck || (busy_cnt != 0);

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle; inputs are driven and outputs sampled at the negedge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // n counts cycles since the request was first presented.
  task automatic wait_ack(input string tag, input int start, input int exp_lat);
    int n;
    n = start;
    do begin
      step();
      n++;
    end while (!(m0_ack || m1_ack) && n < start + 40);
    check({tag, "_lat"}, 64'(n), 64'(exp_lat));
  endtask

  initial begin
    // Reset values.
    #2;
    check("rst_read", sram_read, 0);
    check("rst_write", sram_write, 0);
    check("rst_ack", {m0_ack, m1_ack, m0_err, m1_err}, 0);
    check("rst_grant", grant, 0);
    check("rst_addr", {sram_addr, sram_sel}, 0);
    check("rst_rdata", {m0_rdata, m1_rdata}, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Contention: alternation starts with m0 right after reset.
    m0_addr = 32'h100; m1_addr = 32'h200; sram_rdata = 32'hA5A5_0001;
    m0_req = 1'b1; m1_req = 1'b1;
    for (int t = 0; t < 4; t++) begin
      wait_ack("cont", 0, 4);
      check("cont_grant", grant, 64'(t % 2));
      check("cont_m0_ack", m0_ack, 64'(t % 2 == 0));
      check("cont_m1_ack", m1_ack, 64'(t % 2 == 1));
      check("cont_addr", sram_addr, (t % 2 == 1) ? 64'h200 : 64'h100);
      if (t % 2 == 0) m0_req = 1'b0; else m1_req = 1'b0;
      if (t == 3) begin
        m0_req = 1'b0;
        m1_req = 1'b0;
      end
      step();
      if (t != 3) begin
        if (t % 2 == 0) m0_req = 1'b1; else m1_req = 1'b1;
      end
    end
    step();

    // Single read by m0 with busy high for 3 cycles.
    m0_we = 1'b0; m0_addr = 32'h10; busy_len = 3; sram_rdata = 32'hDEAD_BEEF;
    m0_req = 1'b1;
    step();
    check("rd_strobe", {sram_read, sram_write}, 2'b10);
    check("rd_addr", sram_addr, 32'h10);
    check("rd_grant", grant, 0);
    step();
    check("rd_strobe_1cyc", sram_read, 0);
    wait_ack("rd", 2, 6);
    check("rd_rdata", m0_rdata, 32'hDEAD_BEEF);
    check("rd_err", m0_err, 0);
    check("rd_m1_quiet", {m1_ack, m1_rdata}, 0);
    m0_req = 1'b0;
    step();
    check("rd_ack_pulse", {m0_ack, m0_rdata}, 0);

    // Single write by m1.
    m1_we = 1'b1; m1_addr = 32'h20; m1_wdata = 32'h1234_5678; m1_sel = 4'hF;
    busy_len = 0; m1_req = 1'b1;
    step();
    check("wr_strobe", {sram_read, sram_write}, 2'b01);
    check("wr_fields", {sram_addr, sram_wdata, sram_sel}, {32'h20, 32'h1234_5678, 4'hF});
    check("wr_grant", grant, 1);
    wait_ack("wr", 1, 4);
    check("wr_rdata", {m1_rdata, m1_err}, 0);
    check("wr_m0_quiet", m0_ack, 0);
    m1_req = 1'b0;
    step();

    // Timeout with busy stuck high, then a normal m1 read.
    m0_we = 1'b0; m0_addr = 32'h30; busy_stuck = 1'b1; sram_rdata = 32'h5555_AAAA;
    m0_req = 1'b1;
    step();
    check("to_strobe", sram_read, 1);
    wait_ack("to", 1, 11);
    check("to_err", m0_err, 1);
    check("to_rdata", m0_rdata, 0);
    m0_req = 1'b0; busy_stuck = 1'b0;
    step();
    m1_we = 1'b0; m1_addr = 32'h34; busy_len = 1; m1_req = 1'b1;
    wait_ack("post_to", 0, 4);
    check("post_to_ok", {m1_ack, m1_err, m1_rdata}, {1'b1, 1'b0, 32'h5555_AAAA});
    m1_req = 1'b0;
    step();

    // Field change on the granted master during WAIT has no effect.
    m0_addr = 32'h40; busy_len = 4; m0_req = 1'b1;
    step();
    step();
    m0_addr = 32'h99;
    wait_ack("fld", 2, 7);
    check("fld_addr", sram_addr, 32'h40);
    m0_req = 1'b0;
    step();

    // Reset during WAIT of an m1 transaction.
    m1_addr = 32'h50; busy_stuck = 1'b1; m1_req = 1'b1;
    step();
    step();
    step();
    rst = 1'b1;
    #1;
    check("rstw_grant", grant, 0);
    check("rstw_outs", {sram_read, sram_write, m0_ack, m1_ack, m1_err}, 0);
    busy_stuck = 1'b0; busy_len = 0;
    step();
    check("rstw_no_ack", m1_ack, 0);
    rst = 1'b0;
    m0_req = 1'b1;
    wait_ack("rstw_tie", 0, 4);
    check("rstw_tie_m0", {m0_ack, m1_ack, grant}, 3'b100);
    m0_req = 1'b0; m1_req = 1'b0;
    step();
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
